// File: rtl/semaforo_intersection.sv
// semaforo_intersection: round-robin N-way traffic controller with all-red clearance and maintenance override
module semaforo_intersection #(
  parameter int WIDTH      = 32,
  parameter int N_WAYS     = 4,
  parameter int FLASH_HALF = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      maintenance,
  input  logic [N_WAYS-1:0]         way_enable,
  input  logic [WIDTH-1:0]          green_duration,
  input  logic [WIDTH-1:0]          yellow_duration,
  input  logic [WIDTH-1:0]          all_red_duration,
  input  logic [N_WAYS-1:0]         manual_red,
  input  logic [N_WAYS-1:0]         manual_yellow,
  input  logic [N_WAYS-1:0]         manual_green,
  output logic [N_WAYS-1:0]         red,
  output logic [N_WAYS-1:0]         yellow,
  output logic [N_WAYS-1:0]         green,
  output logic [$clog2(N_WAYS)-1:0] active_way,
  output logic                      conflict
);
  localparam int AW = $clog2(N_WAYS);
  localparam int FW = $clog2(FLASH_HALF + 1);
  typedef enum logic [2:0] {IDLE, GREEN, YELLOW, ALL_RED, MAINT} state_t;
  state_t            r_state;
  logic [WIDTH-1:0]  r_timer;
  logic [AW-1:0]     r_last;
  logic [FW-1:0]     r_flash;
  logic [AW-1:0]     w_base, w_next, w_idx;
  logic [N_WAYS-1:0] w_onehot, w_cur;
  logic              w_expire, w_multi, w_enter;
  function automatic logic [WIDTH-1:0] ld(input logic [WIDTH-1:0] d);
    return d == '0 ? WIDTH'(1) : d;
  endfunction
  // Searching from N_WAYS-1 makes the "next" way the lowest enabled one.
  always_comb begin
    w_base = r_state == IDLE ? AW'(N_WAYS - 1) : r_last;
    w_next = w_base;
    w_idx  = '0;
    for (int i = N_WAYS; i >= 1; i--) begin
      w_idx = AW'((int'(w_base) + i) % N_WAYS);
      if (way_enable[w_idx]) w_next = w_idx;
    end
  end
  assign w_onehot = N_WAYS'(1) << w_next;
  assign w_cur    = N_WAYS'(1) << r_last;
  assign w_expire = r_timer <= WIDTH'(1);
  assign w_multi  = |(manual_green & (manual_green - N_WAYS'(1)));
  assign w_enter  = start && |way_enable && (r_state == IDLE || (r_state == ALL_RED && w_expire));
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_timer    <= '0;
      r_last     <= '0;
      r_flash    <= '0;
      red        <= '1;
      yellow     <= '0;
      green      <= '0;
      active_way <= '0;
      conflict   <= '0;
    end else if (maintenance) begin
      r_state  <= MAINT;
      conflict <= w_multi;
      red      <= w_multi ? '0 : manual_red;
      green    <= w_multi ? '0 : manual_green;
      if (!w_multi) yellow <= manual_yellow;
      else if (!conflict) begin
        yellow  <= '1;
        r_flash <= FW'(1);
      end else if (r_flash == FW'(FLASH_HALF)) begin
        yellow  <= ~yellow;
        r_flash <= FW'(1);
      end else r_flash <= r_flash + FW'(1);
    end else if (w_enter) begin
      r_state    <= GREEN;
      r_timer    <= ld(green_duration);
      r_last     <= w_next;
      active_way <= w_next;
      green      <= w_onehot;
      red        <= ~w_onehot;
      yellow     <= '0;
    end else begin
      case (r_state)
        IDLE: r_timer <= '0;
        GREEN:
          if (w_expire) begin
            r_state <= YELLOW;
            r_timer <= ld(yellow_duration);
            green   <= '0;
            yellow  <= w_cur;
          end else r_timer <= r_timer - WIDTH'(1);
        YELLOW:
          if (w_expire) begin
            r_state <= ALL_RED;
            r_timer <= ld(all_red_duration);
            yellow  <= '0;
            red     <= '1;
          end else r_timer <= r_timer - WIDTH'(1);
        ALL_RED:
          if (w_expire) begin
            r_state <= IDLE;
            r_timer <= '0;
          end else r_timer <= r_timer - WIDTH'(1);
        MAINT: begin
          r_state  <= ALL_RED;
          r_timer  <= ld(all_red_duration);
          r_last   <= AW'(N_WAYS - 1);
          red      <= '1;
          yellow   <= '0;
          green    <= '0;
          conflict <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_semaforo_intersection.sv
// tb_semaforo_intersection: schedule-expansion reference model feeding a per-cycle scoreboard
module tb_semaforo_intersection;
  localparam int N  = 4;
  localparam int AW = 2;
  localparam int FH = 4;
  typedef struct packed {
    logic [N-1:0]  r;
    logic [N-1:0]  y;
    logic [N-1:0]  g;
    logic [AW-1:0] aw;
    logic          c;
  } frame_t;
  logic          clk = 0;
  logic          rst = 1, start = 0, maintenance = 0;
  logic [N-1:0]  way_enable = '1, manual_red = '0, manual_yellow = '0, manual_green = '0;
  logic [31:0]   g_dur = 7, y_dur = 3, ar_dur = 2;
  logic [N-1:0]  red, yellow, green;
  logic [AW-1:0] active_way;
  logic          conflict;
  int            n_tests = 0, n_fail = 0;
  frame_t        scb[$];
  frame_t        sched[$];
  bit            m_maint = 0, m_restart = 1, m_conf = 0;
  int            m_last = 0, m_aw = 0, m_fc = 0;

  semaforo_intersection #(.WIDTH(32), .N_WAYS(N), .FLASH_HALF(FH)) dut (
    .clk(clk), .rst(rst), .start(start), .maintenance(maintenance), .way_enable(way_enable),
    .green_duration(g_dur), .yellow_duration(y_dur), .all_red_duration(ar_dur),
    .manual_red(manual_red), .manual_yellow(manual_yellow), .manual_green(manual_green),
    .red(red), .yellow(yellow), .green(green), .active_way(active_way), .conflict(conflict)
  );

  always #5 clk = ~clk;

  function automatic int dur(input logic [31:0] d);
    return d == 0 ? 1 : int'(d);
  endfunction

  function automatic frame_t mk(input logic [N-1:0] r, input logic [N-1:0] y, input logic [N-1:0] g, input int aw, input logic c);
    mk = '{r: r, y: y, g: g, aw: AW'(aw), c: c};
  endfunction

  // Expected outputs after the coming edge, from a queue of pre-expanded lamp frames.
  function automatic frame_t model_edge();
    frame_t e;
    logic [N-1:0] oh;
    int k;
    bit found;
    if (rst) begin
      sched.delete();
      m_maint = 0; m_restart = 1; m_aw = 0; m_conf = 0;
      return mk('1, '0, '0, 0, 0);
    end
    if (maintenance) begin
      sched.delete();
      m_maint = 1;
      if ($countones(manual_green) > 1) begin
        if (!m_conf) m_fc = 0;
        e = mk('0, ((m_fc / FH) % 2 == 0) ? '1 : '0, '0, m_aw, 1);
        m_fc++;
        m_conf = 1;
      end else begin
        e = mk(manual_red, manual_yellow, manual_green, m_aw, 0);
        m_conf = 0;
      end
      return e;
    end
    if (m_maint) begin
      m_maint = 0; m_conf = 0; m_restart = 1;
      repeat (dur(ar_dur)) sched.push_back(mk('1, '0, '0, m_aw, 0));
    end
    if (sched.size() == 0) begin
      if (start && |way_enable) begin
        found = 0; k = 0;
        if (!m_restart)
          for (int c = m_last + 1; c < N; c++) if (!found && way_enable[c]) begin k = c; found = 1; end
        for (int c = 0; c < N; c++) if (!found && way_enable[c]) begin k = c; found = 1; end
        m_last = k; m_aw = k; m_restart = 0;
        oh = N'(1) << k;
        repeat (dur(g_dur))  sched.push_back(mk(~oh, '0, oh, k, 0));
        repeat (dur(y_dur))  sched.push_back(mk(~oh, oh, '0, k, 0));
        repeat (dur(ar_dur)) sched.push_back(mk('1, '0, '0, k, 0));
      end else begin
        m_restart = 1;
        sched.push_back(mk('1, '0, '0, m_aw, 0));
      end
    end
    return sched.pop_front();
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) begin
      scb.push_back(model_edge());
      @(posedge clk);
      #2;
    end
  endtask

  task automatic do_reset(input logic [31:0] g, input logic [31:0] y, input logic [31:0] a, input logic [N-1:0] en);
    rst = 1; start = 0; maintenance = 0;
    g_dur = g; y_dur = y; ar_dur = a; way_enable = en;
    tick(2);
    rst = 0;
  endtask

  initial begin : monitor
    frame_t e, got;
    forever begin
      @(posedge clk);
      #1;
      if (scb.size() != 0) begin
        e = scb.pop_front();
        got = '{r: red, y: yellow, g: green, aw: active_way, c: conflict};
        n_tests++;
        if (got !== e) begin
          n_fail++;
          $display("FAIL frame t=%0t got r=%b y=%b g=%b aw=%0d c=%b want r=%b y=%b g=%b aw=%0d c=%b",
                   $time, got.r, got.y, got.g, got.aw, got.c, e.r, e.y, e.g, e.aw, e.c);
        end
        n_tests++;
        if ($countones(green) > 1) begin
          n_fail++;
          $display("FAIL one_green t=%0t got g=%b want at most one bit", $time, green);
        end
      end
    end
  end

  initial begin : stim
    // four ways, G7 Y3 AR2, two full rotations
    do_reset(7, 3, 2, 4'b1111);
    start = 1;
    tick(100);
    // only ways 1 and 3 enabled
    do_reset(5, 2, 1, 4'b1010);
    start = 1;
    tick(40);
    // zero durations behave as one cycle
    do_reset(0, 0, 0, 4'b1111);
    start = 1;
    tick(30);
    // maintenance during way2 green, then conflicting manual greens, then release
    do_reset(7, 3, 2, 4'b1111);
    start = 1;
    tick(26);
    maintenance = 1; manual_red = 4'b1111; manual_yellow = 0; manual_green = 0;
    tick(5);
    manual_green = 4'b0011;
    tick(20);
    manual_green = 4'b0100; manual_red = 4'b1011;
    tick(3);
    manual_green = 4'b1100;
    tick(6);
    maintenance = 0;
    tick(20);
    // start released during way2 green
    do_reset(7, 3, 2, 4'b1111);
    start = 1;
    tick(27);
    start = 0;
    tick(40);
    start = 1;
    tick(10);
    // reset pulse during way1 yellow
    do_reset(7, 3, 2, 4'b1111);
    start = 1;
    tick(20);
    rst = 1;
    tick(1);
    rst = 0;
    tick(6);
    // randomized traffic
    for (int ep = 0; ep < 25; ep++) begin
      do_reset($urandom_range(0, 5), $urandom_range(0, 4), $urandom_range(0, 3), 4'($urandom_range(0, 15)));
      start = 1;
      for (int c = 0; c < 150; c++) begin
        if ($urandom_range(0, 99) < 3) maintenance = ~maintenance;
        if ($urandom_range(0, 99) < 5) start = ~start;
        if ($urandom_range(0, 99) < 5) way_enable = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 99) < 30) begin
          manual_red    = 4'($urandom);
          manual_yellow = 4'($urandom);
          manual_green  = ($urandom_range(0, 1) == 1) ? 4'($urandom) : (4'b0001 << $urandom_range(0, 3));
        end
        rst = $urandom_range(0, 199) == 0;
        tick(1);
      end
      rst = 0;
    end
    repeat (3) @(posedge clk);
    #3;
    n_tests++;
    if (scb.size() != 0) begin
      n_fail++;
      $display("FAIL drain got %0d pending want 0", scb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
